// File: rtl/ipg_tx.sv
// Transmit-side IPG payload inserter: fills idle/control slots of 64b/66b control
// blocks with buffered side-channel bits, LSB-first, one registered cycle of latency.
module ipg_tx #(
   parameter bit ENABLE_START_SLOTS = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] encoded_tx_data,
   input  logic [1:0]  encoded_tx_hdr,
   input  logic [63:0] s_ipg_tdata,
   input  logic        s_ipg_tvalid,
   output logic        s_ipg_tready,
   output logic [63:0] ipg_encoded_tx_data,
   output logic [1:0]  ipg_encoded_tx_hdr,
   output logic [5:0]  tx_len,
   output logic [7:0]  buf_level
);

   logic [127:0] r_buf;
   logic [7:0]   r_count;
   logic         r_tready;
   logic [63:0]  r_data;
   logic [1:0]   r_hdr;
   logic [5:0]   r_len;

   logic [7:0]   w_cap;
   logic [5:0]   w_lo;
   logic         w_full;
   logic [7:0]   w_used;
   logic         w_accept;
   logic [63:0]  w_low_mask;
   logic [63:0]  w_slot_mask;
   logic [63:0]  w_fill;
   logic [63:0]  w_data_next;
   logic [127:0] w_buf_next;
   logic [7:0]   w_count_next;

   // Slot position and capacity of the incoming block
   always_comb begin
      w_cap = 8'd0;
      w_lo  = 6'd0;
      if (encoded_tx_hdr == 2'b01) begin
         case (encoded_tx_data[7:0])
            8'h1e:        begin w_cap = 8'd56; w_lo = 6'd8;  end
            8'h2d, 8'h33: begin w_cap = ENABLE_START_SLOTS ? 8'd24 : 8'd0; w_lo = 6'd8; end
            8'h4b:        begin w_cap = 8'd24; w_lo = 6'd40; end
            8'h87:        begin w_cap = 8'd48; w_lo = 6'd16; end
            8'h99:        begin w_cap = 8'd40; w_lo = 6'd24; end
            8'haa:        begin w_cap = 8'd32; w_lo = 6'd32; end
            8'hb4:        begin w_cap = 8'd24; w_lo = 6'd40; end
            8'hcc:        begin w_cap = 8'd16; w_lo = 6'd48; end
            8'hd2:        begin w_cap = 8'd8;  w_lo = 6'd56; end
            default:      begin w_cap = 8'd0;  w_lo = 6'd0;  end
         endcase
      end else begin
         w_cap = 8'd0;
         w_lo  = 6'd0;
      end
   end

   // Slot fill and buffer bookkeeping; a short buffer zeroes the slot (filler)
   always_comb begin
      w_full       = (w_cap != 8'd0) && (r_count >= w_cap);
      w_used       = w_full ? w_cap : 8'd0;
      w_accept     = s_ipg_tvalid & r_tready;
      w_low_mask   = (64'h1 << w_cap) - 64'h1;
      w_slot_mask  = w_low_mask << w_lo;
      w_fill       = w_full ? ((r_buf[63:0] & w_low_mask) << w_lo) : 64'h0;
      w_data_next  = (encoded_tx_data & ~w_slot_mask) | w_fill;
      w_buf_next   = r_buf >> w_used;
      w_count_next = r_count - w_used;
      if (w_accept) begin
         w_buf_next   = w_buf_next | ({64'h0, s_ipg_tdata} << (r_count - w_used));
         w_count_next = w_count_next + 8'd64;
      end else begin
         w_buf_next   = w_buf_next;
         w_count_next = w_count_next;
      end
   end

   // Registered block output, buffer state and ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf    <= 128'h0;
         r_count  <= 8'd0;
         r_tready <= 1'b0;
         r_data   <= 64'h0;
         r_hdr    <= 2'b00;
         r_len    <= 6'd0;
      end else begin
         r_buf    <= w_buf_next;
         r_count  <= w_count_next;
         r_tready <= (w_count_next <= 8'd64);
         r_data   <= w_data_next;
         r_hdr    <= encoded_tx_hdr;
         r_len    <= w_used[5:0];
      end
   end

   assign s_ipg_tready        = r_tready;
   assign ipg_encoded_tx_data = r_data;
   assign ipg_encoded_tx_hdr  = r_hdr;
   assign tx_len              = r_len;
   assign buf_level           = r_count;

endmodule

// File: tb/tb_ipg_tx.sv
// Directed self-checking bench for ipg_tx; a second instance covers
// ENABLE_START_SLOTS=0.
module tb_ipg_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] encoded_tx_data = 64'h0;
   logic [1:0]  encoded_tx_hdr = 2'b00;
   logic [63:0] s_ipg_tdata = 64'h0;
   logic        s_ipg_tvalid = 1'b0;

   logic        s_ipg_tready, s_ipg_tready0;
   logic [63:0] ipg_encoded_tx_data, ipg_encoded_tx_data0;
   logic [1:0]  ipg_encoded_tx_hdr, ipg_encoded_tx_hdr0;
   logic [5:0]  tx_len, tx_len0;
   logic [7:0]  buf_level, buf_level0;

   int n_vec = 0;
   int n_err = 0;

   ipg_tx #(.ENABLE_START_SLOTS(1'b1)) dut (
      .clk(clk), .rst(rst),
      .encoded_tx_data(encoded_tx_data), .encoded_tx_hdr(encoded_tx_hdr),
      .s_ipg_tdata(s_ipg_tdata), .s_ipg_tvalid(s_ipg_tvalid), .s_ipg_tready(s_ipg_tready),
      .ipg_encoded_tx_data(ipg_encoded_tx_data), .ipg_encoded_tx_hdr(ipg_encoded_tx_hdr),
      .tx_len(tx_len), .buf_level(buf_level)
   );

   ipg_tx #(.ENABLE_START_SLOTS(1'b0)) dut0 (
      .clk(clk), .rst(rst),
      .encoded_tx_data(encoded_tx_data), .encoded_tx_hdr(encoded_tx_hdr),
      .s_ipg_tdata(s_ipg_tdata), .s_ipg_tvalid(s_ipg_tvalid), .s_ipg_tready(s_ipg_tready0),
      .ipg_encoded_tx_data(ipg_encoded_tx_data0), .ipg_encoded_tx_hdr(ipg_encoded_tx_hdr0),
      .tx_len(tx_len0), .buf_level(buf_level0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one block (and optionally a payload word), then advance one clock
   task automatic blk(input logic [1:0] h, input logic [63:0] d, input logic v, input logic [63:0] td);
      encoded_tx_hdr  = h;
      encoded_tx_data = d;
      s_ipg_tvalid    = v;
      s_ipg_tdata     = td;
      step();
   endtask

   task automatic chk_out(input string tag, input logic [63:0] d, input logic [1:0] h,
                          input logic [5:0] l, input logic [7:0] lvl, input logic rdy);
      chk({tag, ".data"},  ipg_encoded_tx_data, d);
      chk({tag, ".hdr"},   {62'h0, ipg_encoded_tx_hdr}, {62'h0, h});
      chk({tag, ".len"},   {58'h0, tx_len}, {58'h0, l});
      chk({tag, ".level"}, {56'h0, buf_level}, {56'h0, lvl});
      chk({tag, ".ready"}, {63'h0, s_ipg_tready}, {63'h0, rdy});
   endtask

   initial begin
      blk(2'b01, 64'h1234_5678_9abc_de1e, 1'b1, 64'hffff_ffff_ffff_ffff);
      step();
      chk_out("in_reset", 64'h0, 2'b00, 6'd0, 8'd0, 1'b0);

      rst = 1'b0;
      blk(2'b01, 64'hffff_ffff_ffff_ff1e, 1'b0, 64'h0);
      chk_out("post_reset_1e", 64'h0000_0000_0000_001e, 2'b01, 6'd0, 8'd0, 1'b1);

      blk(2'b10, 64'hdead_beef_0000_1111, 1'b1, 64'h0123_4567_89ab_cdef);
      chk_out("accept_w0", 64'hdead_beef_0000_1111, 2'b10, 6'd0, 8'd64, 1'b1);
      blk(2'b01, 64'haaaa_aaaa_aaaa_aa1e, 1'b0, 64'h0);
      chk_out("fill_1e", 64'h2345_6789_abcd_ef1e, 2'b01, 6'd56, 8'd8, 1'b1);
      blk(2'b01, 64'h5555_5555_5555_55d2, 1'b0, 64'h0);
      chk_out("tail_d2", 64'h0155_5555_5555_55d2, 2'b01, 6'd8, 8'd0, 1'b1);

      blk(2'b10, 64'h1234_5678_9abc_def0, 1'b1, 64'hfedc_ba98_7654_3210);
      chk_out("data_pass", 64'h1234_5678_9abc_def0, 2'b10, 6'd0, 8'd64, 1'b1);
      blk(2'b01, 64'h0000_0000_0000_00d2, 1'b0, 64'h0);
      chk_out("fill_d2", 64'h1000_0000_0000_00d2, 2'b01, 6'd8, 8'd56, 1'b1);
      blk(2'b01, 64'h0000_0000_0000_001e, 1'b0, 64'h0);
      chk_out("drain_1e", 64'hfedc_ba98_7654_321e, 2'b01, 6'd56, 8'd0, 1'b1);

      blk(2'b10, 64'h0, 1'b1, 64'h1111_2222_3333_4444);
      chk_out("fill_w1", 64'h0, 2'b10, 6'd0, 8'd64, 1'b1);
      blk(2'b10, 64'h0, 1'b1, 64'h5555_6666_7777_8888);
      chk_out("fill_w2", 64'h0, 2'b10, 6'd0, 8'd128, 1'b0);
      blk(2'b10, 64'h0, 1'b1, 64'h9999_9999_9999_9999);
      chk_out("full_hold", 64'h0, 2'b10, 6'd0, 8'd128, 1'b0);
      blk(2'b01, 64'h0000_0000_0000_0087, 1'b1, 64'h9999_9999_9999_9999);
      chk_out("fill_87", 64'h2222_3333_4444_0087, 2'b01, 6'd48, 8'd80, 1'b0);
      blk(2'b01, 64'h0000_0000_0000_001e, 1'b1, 64'h9999_9999_9999_9999);
      chk_out("span_1e", 64'h6677_7788_8811_111e, 2'b01, 6'd56, 8'd24, 1'b1);

      blk(2'b01, 64'h0000_0000_0000_00d2, 1'b0, 64'h0);
      chk_out("lvl16_d2", 64'h6600_0000_0000_00d2, 2'b01, 6'd8, 8'd16, 1'b1);
      blk(2'b01, 64'hffff_ffff_1234_56aa, 1'b0, 64'h0);
      chk_out("short_aa", 64'h0000_0000_1234_56aa, 2'b01, 6'd0, 8'd16, 1'b1);
      blk(2'b01, 64'h0000_0000_0000_00cc, 1'b0, 64'h0);
      chk_out("fill_cc", 64'h5555_0000_0000_00cc, 2'b01, 6'd16, 8'd0, 1'b1);

      blk(2'b10, 64'h0, 1'b1, 64'h0bad_c0de_cafe_f00d);
      chk_out("accept_w3", 64'h0, 2'b10, 6'd0, 8'd64, 1'b1);
      blk(2'b01, 64'haaaa_aaaa_ffff_ff33, 1'b0, 64'h0);
      chk_out("fill_33", 64'haaaa_aaaa_fef0_0d33, 2'b01, 6'd24, 8'd40, 1'b1);
      chk("nostart.data", ipg_encoded_tx_data0, 64'haaaa_aaaa_ffff_ff33);
      chk("nostart.len", {58'h0, tx_len0}, 64'h0);
      chk("nostart.level", {56'h0, buf_level0}, 64'd64);
      blk(2'b01, 64'h0000_0000_0011_2299, 1'b0, 64'h0);
      chk_out("fill_99", 64'h0bad_c0de_ca11_2299, 2'b01, 6'd40, 8'd0, 1'b1);

      blk(2'b10, 64'h0, 1'b1, 64'h89ab_cdef_0123_4567);
      chk_out("accept_w4", 64'h0, 2'b10, 6'd0, 8'd64, 1'b1);
      blk(2'b01, 64'h0000_0000_0000_001e, 1'b1, 64'hdead_beef_dead_beef);
      chk_out("consume_accept", 64'habcd_ef01_2345_671e, 2'b01, 6'd56, 8'd72, 1'b0);

      rst = 1'b1;
      #1;
      chk_out("async_rst", 64'h0, 2'b00, 6'd0, 8'd0, 1'b0);
      blk(2'b10, 64'h0, 1'b0, 64'h0);
      rst = 1'b0;
      blk(2'b10, 64'h0, 1'b0, 64'h0);
      blk(2'b10, 64'h0, 1'b1, 64'h1357_9bdf_2468_ace0);
      chk_out("rst_accept", 64'h0, 2'b10, 6'd0, 8'd64, 1'b1);
      blk(2'b01, 64'h0000_0000_0000_001e, 1'b0, 64'h0);
      chk_out("rst_fresh_1e", 64'h579b_df24_68ac_e01e, 2'b01, 6'd56, 8'd8, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
